riscv_muldiv_unit: RTL and testbench



---
 rtl/riscv_muldiv_unit_pkg.sv | 29 ++
 rtl/riscv_muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_unit_pkg.sv
// Shared core definitions for the RV32M/RV64M multiply/divide unit.
// Op encoding follows instruction funct3 so decode can pass it straight through.
package riscv_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_div_op(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/riscv_muldiv_unit.sv
// Iterative multiply (shift-add) / restoring divide, one bit per cycle; MULDIV_EARLY_OUT_EN skips CALC for trivial ops.
// Latency DATA_WIDTH+2 cycles counting the accept cycle (2 with early-out); result held in DONE until out_ready.
module riscv_muldiv_unit
    import riscv_muldiv_unit_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    localparam int CNT_BITS   = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  busy
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(DATA_WIDTH - 1);
    localparam logic [W-1:0]        MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    muldiv_state_t       r_state, w_state_nxt;
    muldiv_op_t          r_op;
    logic [CNT_BITS-1:0] r_cnt;
    logic [2*W-1:0]      r_acc;
    logic [W-1:0]        r_opnd;
    logic                r_neg_q, r_neg_r, r_dz;
    logic [W-1:0]        r_result;

    muldiv_op_t     w_op;
    logic           w_accept, w_sa, w_sb, w_div, w_a_zero, w_b_zero, w_ovf, w_early;
    logic [W-1:0]   w_mag_a, w_mag_b;
    logic [2*W-1:0] w_init_acc, w_early_acc, w_step, w_prod;
    logic [W:0]     w_sum, w_rem_sh;
    logic [W+1:0]   w_trial;
    logic [W-1:0]   w_rem_nxt, w_fix_res;

    assign w_op     = muldiv_op_t'(in_op);
    assign w_accept = in_valid && (r_state == IDLE) && !flush;
    assign w_div    = is_div_op(w_op);
    assign w_sa     = in_a[W-1] && (w_op == OP_MULH || w_op == OP_MULHSU || w_op == OP_DIV || w_op == OP_REM);
    assign w_sb     = in_b[W-1] && (w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM);
    assign w_mag_a  = neg_if(in_a, w_sa);
    assign w_mag_b  = neg_if(in_b, w_sb);
    assign w_a_zero = (in_a == '0);
    assign w_b_zero = (in_b == '0);
    assign w_ovf    = (w_op == OP_DIV || w_op == OP_REM) && (in_a == MOST_NEG) && (in_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = w_a_zero || w_b_zero || (w_div && w_ovf);
`else
    assign w_early = 1'b0;
`endif

    // Early results are loaded in the same {rem,quo} / product layout CALC would leave behind
    always_comb begin
        w_init_acc  = {{W{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
        w_early_acc = '0;
        if (w_div && w_b_zero)
            w_early_acc = {w_mag_a, {W{1'b1}}};
        else if (w_div && w_ovf)
            w_early_acc = {{W{1'b0}}, w_mag_a};
    end

    always_comb begin
        w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
        w_rem_sh  = r_acc[2*W-1:W-1];
        w_trial   = {1'b0, w_rem_sh} - {2'b00, r_opnd};
        w_rem_nxt = w_trial[W+1] ? w_rem_sh[W-1:0] : w_trial[W-1:0];
        if (is_div_op(r_op))
            w_step = {w_rem_nxt, r_acc[W-2:0], ~w_trial[W+1]};
        else
            w_step = {w_sum, r_acc[W-1:1]};
    end

    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        case (r_op)
            OP_MUL:                      w_fix_res = w_prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*W-1:W];
            OP_DIV, OP_DIVU:             w_fix_res = r_dz ? {W{1'b1}} : neg_if(r_acc[W-1:0], r_neg_q);
            default:                     w_fix_res = neg_if(r_acc[2*W-1:W], r_neg_r);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == IDLE);
        out_valid   = (r_state == DONE);
        busy        = (r_state != IDLE);
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = w_early ? FIX : CALC;
                CALC:    if (r_cnt == LAST_ITER) w_state_nxt = FIX;
                FIX:     w_state_nxt = DONE;
                default: if (out_ready) w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op    <= w_op;
                    r_cnt   <= '0;
                    r_opnd  <= w_div ? w_mag_b : w_mag_a;
                    r_acc   <= w_early ? w_early_acc : w_init_acc;
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                    r_dz    <= w_div && w_b_zero;
                end
                CALC: if (!flush) begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
                end
                FIX: if (!flush) r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign out_result = r_result;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed self-checking bench for riscv_muldiv_unit (DATA_WIDTH=32).
module tb_riscv_muldiv_unit;
    import riscv_muldiv_unit_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'b000;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    riscv_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic trivial;
        trivial = (a == 32'd0) || (b == 32'd0) ||
                  (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (EARLY_EN && trivial) ? 2 : 34;
    endfunction

    // Drives one op, returns the cycle (accept cycle = 1) in which out_valid was first seen, -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        logic seen;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
        lat = 1; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        res = out_result;
        if (!seen) lat = -1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (out_result !== 32'h0) begin n_errors++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    endtask

    task automatic test_multiply();
        logic [2:0]  ops [4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ex  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== ex[i]) begin n_errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, ex[i]); end
            n_checks++; if (lat !== exp_latency(ops[i], as[i], bs[i])) begin n_errors++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, exp_latency(ops[i], as[i], bs[i])); end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ex  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== ex[i]) begin n_errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, ex[i]); end
            n_checks++; if (lat !== exp_latency(ops[i], as[i], bs[i])) begin n_errors++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, exp_latency(ops[i], as[i], bs[i])); end
        end
    endtask

    task automatic test_div_corners();
        logic [2:0]  ops [5] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_REM};
        logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ex  [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== ex[i]) begin n_errors++; $display("FAIL corner_result[%0d]: got %h want %h", i, res, ex[i]); end
            n_checks++; if (lat !== exp_latency(ops[i], as[i], bs[i])) begin n_errors++; $display("FAIL corner_latency[%0d]: got %0d want %0d", i, lat, exp_latency(ops[i], as[i], bs[i])); end
        end
    endtask

    task automatic test_hold();
        int wait_cyc;
        @(negedge clk);
        in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL hold_timeout: out_valid %b want 1", out_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_result !== 32'd14) begin n_errors++; $display("FAIL hold_result[%0d]: got %h want %h", i, out_result, 32'd14); end
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL hold_release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
        n_checks++; if (out_result !== 32'd14) begin n_errors++; $display("FAIL hold_result_kept: got %h want %h", out_result, 32'd14); end
    endtask

    task automatic test_flush_reset();
        logic seen;
        logic [31:0] res;
        int lat;
        @(negedge clk);
        in_op = OP_MULHU; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL flush_no_output: saw out_valid %b want 0", seen); end
        n_checks++; if (out_result !== 32'd14) begin n_errors++; $display("FAIL flush_result_kept: got %h want %h", out_result, 32'd14); end

        @(negedge clk);
        in_op = OP_MUL; in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL flush_blocks_accept: busy %b want 0", busy); end

        @(negedge clk);
        in_op = OP_DIV; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_checks++; if (out_result !== 32'd0) begin n_errors++; $display("FAIL rst_mid_result: got %h want 0", out_result); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rst_no_output: saw out_valid %b want 0", seen); end

        run_op(OP_MUL, 32'd3, 32'd4, res, lat);
        n_checks++; if (res !== 32'd12) begin n_errors++; $display("FAIL post_rst_mul: got %h want %h", res, 32'd12); end
        n_checks++; if (lat !== 34) begin n_errors++; $display("FAIL post_rst_latency: got %0d want 34", lat); end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_multiply();
        test_divide();
        test_div_corners();
        test_hold();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
